// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..DATA_BITS_MAX bits, none/even/odd parity, 1/2 stop, LSB/MSB first).
// Latency: word accepted at edge E from IDLE drives the start bit from edge E+1; frames chain with no idle gap.
// Backpressure: one-word holding register; tx_ready = holding empty, so the source stalls while a word waits.
`timescale 1ns/1ps
module uart_tx_cfg #(
   parameter int DATA_BITS_MAX = 8,
   parameter int CLOCK_FREQ    = 50_000_000,
   parameter int BAUD_RATE     = 115200
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_BITS_MAX-1:0] tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [3:0]               cfg_data_bits,
   input  logic [1:0]               cfg_parity,
   input  logic                     cfg_stop2,
   input  logic                     cfg_msb_first,
   output logic                     tx,
   output logic                     tx_busy,
   output logic                     tx_done
);

   localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [3:0]       DBM4     = 4'(DATA_BITS_MAX);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t state, state_nxt;

   // Holding register: word pre-ordered for transmission plus its frame settings.
   logic                     hold_full;
   logic [DATA_BITS_MAX-1:0] hold_word;
   logic [3:0]               hold_bits;
   logic                     hold_par_en, hold_par_bit, hold_stop2;

   // Frame in flight.
   logic [DATA_BITS_MAX-1:0] shifter;
   logic [3:0]               f_bits, bit_idx;
   logic                     f_par_en, f_par_bit, f_stop2, stop_idx;
   logic [CNT_W-1:0]         cnt;

   // Input-side decode.
   logic [3:0]               nb_eff, sh_amt;
   logic [DATA_BITS_MAX-1:0] rev, mask, ord;
   logic                     in_par_en, in_par_bit;

   logic accept, load, bit_end, last_data, last_stop;

   assign tx_ready  = ~hold_full;
   assign tx_busy   = (state != S_IDLE);
   assign accept    = tx_valid && tx_ready;
   assign bit_end   = (cnt == CNT_LAST);
   assign last_data = (bit_idx == f_bits - 4'd1);
   assign last_stop = (stop_idx == f_stop2);

   // Clamp the width, order the word so bit 0 always goes out first, and precompute parity.
   always_comb begin
      nb_eff = ((cfg_data_bits < 4'd5) || (cfg_data_bits > DBM4)) ? DBM4 : cfg_data_bits;
      sh_amt = DBM4 - nb_eff;
      rev    = '0;
      for (int i = 0; i < DATA_BITS_MAX; i++) rev[i] = tx_data[DATA_BITS_MAX-1-i];
      mask       = {DATA_BITS_MAX{1'b1}} >> sh_amt;
      ord        = cfg_msb_first ? (rev >> sh_amt) : (tx_data & mask);
      in_par_en  = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
      in_par_bit = (^ord) ^ (cfg_parity == 2'd2);
   end

   // Next-state logic; load marks the cycle the holding register is moved into the frame.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      tx_done   = 1'b0;
      case (state)
         S_IDLE:   if (hold_full) begin load = 1'b1; state_nxt = S_START; end
         S_START:  if (bit_end) state_nxt = S_DATA;
         S_DATA:   if (bit_end && last_data) state_nxt = f_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_nxt = S_STOP;
         S_STOP: begin
            if (bit_end && last_stop) begin
               tx_done = 1'b1;
               if (hold_full) begin
                  load      = 1'b1;
                  state_nxt = S_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Holding register: accept wins over unload so a same-cycle refill keeps it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full    <= 1'b0;
         hold_word    <= '0;
         hold_bits    <= '0;
         hold_par_en  <= 1'b0;
         hold_par_bit <= 1'b0;
         hold_stop2   <= 1'b0;
      end else if (accept) begin
         hold_full    <= 1'b1;
         hold_word    <= ord;
         hold_bits    <= nb_eff;
         hold_par_en  <= in_par_en;
         hold_par_bit <= in_par_bit;
         hold_stop2   <= cfg_stop2;
      end else if (load) begin
         hold_full    <= 1'b0;
      end
   end

   // Baud counter, shifter and line driver; tx changes only at bit boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx        <= 1'b1;
         cnt       <= '0;
         shifter   <= '0;
         f_bits    <= '0;
         f_par_en  <= 1'b0;
         f_par_bit <= 1'b0;
         f_stop2   <= 1'b0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
      end else if (load) begin
         tx        <= 1'b0;
         cnt       <= '0;
         shifter   <= hold_word;
         f_bits    <= hold_bits;
         f_par_en  <= hold_par_en;
         f_par_bit <= hold_par_bit;
         f_stop2   <= hold_stop2;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
      end else if (state == S_IDLE) begin
         tx  <= 1'b1;
         cnt <= '0;
      end else begin
         cnt <= bit_end ? '0 : cnt + CNT_W'(1);
         if (bit_end) begin
            case (state)
               S_START: begin
                  tx      <= shifter[0];
                  shifter <= shifter >> 1;
                  bit_idx <= '0;
               end
               S_DATA: begin
                  if (last_data) begin
                     tx <= f_par_en ? f_par_bit : 1'b1;
                  end else begin
                     tx      <= shifter[0];
                     shifter <= shifter >> 1;
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
               S_PARITY: tx <= 1'b1;
               S_STOP: begin
                  tx <= 1'b1;
                  if (!last_stop) stop_idx <= 1'b1;
               end
               default: tx <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg with BAUD_DIV = 4.
// Expected line waveforms come from a frame model built from each accepted word and its settings.
// Directed frames, back-to-back chaining, randomized traffic and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

   localparam int BD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [3:0] cfg_data_bits = 4'd8;
   logic [1:0] cfg_parity = '0;
   logic       cfg_stop2 = 1'b0;
   logic       cfg_msb_first = 1'b0;
   logic       tx, tx_busy, tx_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] bits;
      int          len;
   } frame_t;

   frame_t exp_q[$];

   uart_tx_cfg #(.DATA_BITS_MAX(8), .CLOCK_FREQ(16), .BAUD_RATE(4)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .cfg_msb_first(cfg_msb_first), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Line sequence for one word: start, data bits in send order, optional parity, stop bit(s).
   function automatic frame_t mk(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                                 input logic s2, input logic msb);
      frame_t f;
      int n, p, ones;
      n = (nb < 5 || nb > 8) ? 8 : int'(nb);
      f.bits = '0;
      p = 1;
      ones = 0;
      for (int i = 0; i < n; i++) begin
         logic b;
         b = msb ? d[n-1-i] : d[i];
         f.bits[p] = b;
         if (b) ones++;
         p++;
      end
      if (par == 2'd1 || par == 2'd2) begin
         f.bits[p] = ((ones % 2) == 1) ^ (par == 2'd2);
         p++;
      end
      f.bits[p] = 1'b1;
      p++;
      if (s2) begin
         f.bits[p] = 1'b1;
         p++;
      end
      f.len = p;
      return f;
   endfunction

   // Offer a word until accepted; record its expected frame; scramble inputs afterwards.
   task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                       input logic s2, input logic msb, input bit lat);
      int w;
      w = 0;
      tx_data = d; cfg_data_bits = nb; cfg_parity = par; cfg_stop2 = s2; cfg_msb_first = msb;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         chk("accept_timeout", w, 0);
         tx_valid = 1'b0;
         return;
      end
      exp_q.push_back(mk(d, nb, par, s2, msb));
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
      cfg_data_bits = 4'($urandom); cfg_parity = 2'($urandom);
      cfg_stop2 = 1'($urandom); cfg_msb_first = 1'($urandom);
      chk("rdy_drop", tx_ready, 0);
      if (lat) begin
         chk("lat_tx_hi", tx, 1);
         @(negedge clk);
         chk("lat_tx_lo", tx, 0);
         chk("lat_rdy", tx_ready, 1);
      end
   endtask

   // Watch the line for n frames and check every cycle against the expected frames.
   task automatic check_frames(input int n, input bit contig);
      for (int k = 0; k < n; k++) begin
         int gap;
         frame_t f;
         gap = 0;
         while (tx !== 1'b0 && gap < 400) begin
            chk("idle_busy", tx_busy, 0);
            chk("idle_done", tx_done, 0);
            @(negedge clk);
            gap++;
         end
         if (gap >= 400) begin
            chk("frame_timeout", gap, 0);
            return;
         end
         if (contig && k > 0) chk("gap", gap, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", exp_q.size(), 1);
            return;
         end
         f = exp_q.pop_front();
         for (int b = 0; b < f.len; b++) begin
            for (int c = 0; c < BD; c++) begin
               chk("tx_bit", tx, f.bits[b]);
               chk("busy", tx_busy, 1);
               chk("done", tx_done, (b == f.len - 1 && c == BD - 1));
               @(negedge clk);
            end
         end
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1 LSB first 0xA5, with latency checks
      fork
         send(8'hA5, 4'd8, 2'd0, 1'b0, 1'b0, 1'b1);
         check_frames(1, 1'b0);
      join
      // 8E2 0x07
      fork
         send(8'h07, 4'd8, 2'd1, 1'b1, 1'b0, 1'b0);
         check_frames(1, 1'b0);
      join
      // 7O1 MSB first 0x41
      fork
         send(8'h41, 4'd7, 2'd2, 1'b0, 1'b1, 1'b0);
         check_frames(1, 1'b0);
      join
      // three words back to back; stop2 switches while the first frame is on the line
      fork
         begin
            send(8'h3C, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0);
            send(8'h5A, 4'd8, 2'd0, 1'b1, 1'b0, 1'b0);
            send(8'h0F, 4'd6, 2'd1, 1'b1, 1'b1, 1'b0);
         end
         check_frames(3, 1'b1);
      join
      // randomized traffic including illegal widths
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 6)) @(negedge clk);
               send(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end
         end
         check_frames(30, 1'b0);
      join

      // reset during a data bit of 0x00 with another word held
      repeat (3) @(negedge clk);
      send(8'h00, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0);
      send(8'h55, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk("pre_rst_tx", tx, 0);
      chk("pre_rst_busy", tx_busy, 1);
      chk("pre_rst_ready", tx_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", tx, 1);
      chk("rst_mid_busy", tx_busy, 0);
      chk("rst_mid_ready", tx_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      begin
         int tx_low, done_seen, busy_seen, rdy_low;
         tx_low = 0; done_seen = 0; busy_seen = 0; rdy_low = 0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (tx_done !== 1'b0) done_seen++;
            if (tx_busy !== 1'b0) busy_seen++;
            if (tx_ready !== 1'b1) rdy_low++;
         end
         chk("post_rst_tx_low", tx_low, 0);
         chk("post_rst_done", done_seen, 0);
         chk("post_rst_busy", busy_seen, 0);
         chk("post_rst_ready", rdy_low, 0);
      end
      exp_q.delete();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
